keypad_scanner: RTL and testbench

//  Scans a 4x4 membrane keypad matrix and produces a debounced pressed-key vector that
//  the top level maps onto calc_pkg::buttons_t before sanitize_buttons. Sits directly

---
 rtl/keypad_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: drives one row low at a time, debounces full frames and
// reports newly pressed keys. Optional build macro: KEYPAD_GHOST_REJECT_EN.
module keypad_scanner #(
  parameter int NumRows       = 4,
  parameter int NumCols       = 4,
  parameter int RowDwell      = 1000,
  parameter int DebounceScans = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  output logic [NumRows-1:0]                    row_o,
  input  logic [NumCols-1:0]                    col_i,
  output logic [NumRows*NumCols-1:0]            keys_o,
  output logic                                  key_event_o,
  output logic [$clog2(NumRows*NumCols)-1:0]    key_code_o,
  output logic                                  state_o
);

  localparam int NumKeys = NumRows * NumCols;
  localparam int CodeW   = $clog2(NumKeys);
  localparam int RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int DwellW  = $clog2(RowDwell);
  localparam int StableW = $clog2(DebounceScans + 1);

  typedef enum logic {
    DRIVE  = 1'b0,
    COMMIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [DwellW-1:0]    dwell_q, dwell_d;
  logic [NumKeys-1:0]   raw_q, raw_d;
  logic [NumKeys-1:0]   prev_q, prev_d;
  logic [StableW-1:0]   stable_q, stable_d;
  logic [NumKeys-1:0]   keys_d;
  logic                 event_d;
  logic [CodeW-1:0]     code_d;
  logic [NumRows-1:0]   row_o_d;
  logic [NumKeys-1:0]   new_bits;
  logic [NumCols-1:0]   col_meta, col_sync;
  logic                 ghost;

  // Columns are pulled up, so the synchronizer idles at all-ones (nothing pressed).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_i;
      col_sync <= col_meta;
    end
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  assign ghost = ($countones(raw_q) >= 3);
`else
  assign ghost = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    keys_d   = keys_o;
    event_d  = 1'b0;
    code_d   = key_code_o;
    new_bits = '0;
    case (state_q)
      DRIVE: begin
        if (dwell_q == DwellW'(RowDwell - 1)) begin
          raw_d[row_q*NumCols +: NumCols] = ~col_sync;
          if (row_q == RowW'(NumRows - 1)) begin
            state_d = COMMIT;
          end else begin
            row_d   = row_q + 1'b1;
            dwell_d = '0;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      COMMIT: begin
        // A ghost frame neither advances nor seeds the debounce history.
        if (ghost) begin
          stable_d = '0;
        end else begin
          prev_d = raw_q;
          if (raw_q == prev_q) begin
            stable_d = (stable_q >= StableW'(DebounceScans)) ? StableW'(DebounceScans)
                                                              : stable_q + 1'b1;
          end else begin
            stable_d = StableW'(1);
          end
        end
        if (!ghost && stable_d == StableW'(DebounceScans)) begin
          keys_d   = raw_q;
          new_bits = raw_q & ~keys_o;
          if (|new_bits) begin
            event_d = 1'b1;
            for (int i = NumKeys - 1; i >= 0; i--) begin
              if (new_bits[i]) code_d = CodeW'(i);
            end
          end
        end
        row_d   = '0;
        dwell_d = '0;
        state_d = DRIVE;
      end
      default: state_d = DRIVE;
    endcase
    row_o_d = (state_d == COMMIT) ? '1 : ~(NumRows'(1) << row_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DRIVE;
      row_q       <= '0;
      dwell_q     <= '0;
      raw_q       <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      keys_o      <= '0;
      key_event_o <= 1'b0;
      key_code_o  <= '0;
      row_o       <= '1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      dwell_q     <= dwell_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      keys_o      <= keys_d;
      key_event_o <= event_d;
      key_code_o  <= code_d;
      row_o       <= row_o_d;
    end
  end

  assign state_o = (state_q == COMMIT);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with RowDwell=4, DebounceScans=3 (17-cycle frames).
module tb_keypad_scanner;
  localparam int NR = 4;
  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic [15:0] keys_o;
  logic        key_event_o;
  logic [3:0]  key_code_o;
  logic        state_o;

  logic [15:0] pressed;
  int          checks   = 0;
  int          failures = 0;
  int          ev_cnt   = 0;
  int          base;
  logic [3:0]  exp_row;
  bit          found;

  always #5 clk = ~clk;

  keypad_scanner #(
    .NumRows(NR), .NumCols(NC), .RowDwell(4), .DebounceScans(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .row_o(row_o), .col_i(col_i), .keys_o(keys_o),
    .key_event_o(key_event_o), .key_code_o(key_code_o), .state_o(state_o)
  );

  // Ideal matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_i = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (pressed[r*NC+c] && !row_o[r]) col_i[c] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (rst_ni && key_event_o) ev_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst_ni  = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Returns at the negedge just after a COMMIT cycle (row 0, first dwell cycle).
  task automatic next_frame();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_o == 4'hF) found = 1'b1;
    end
    check("frame_bound", {31'd0, found}, 32'd1);
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
  endtask

  initial begin
    pressed = '0;
    rst_ni  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_row", row_o, 4'hF);
    check("rst_keys", keys_o, 16'h0);
    check("rst_event", key_event_o, 1'b0);
    check("rst_code", key_code_o, 4'h0);
    check("rst_state", state_o, 1'b0);
    rst_ni = 1'b1;

    // 1: idle scan pattern over one whole frame
    next_frame();
    for (int k = 0; k < 17; k++) begin
      exp_row = (k < 16) ? ~(4'b0001 << (k / 4)) : 4'hF;
      check("scan_row", row_o, exp_row);
      check("scan_state", state_o, (k == 16) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    check("idle_keys", keys_o, 16'h0);
    check("idle_events", ev_cnt, 0);

    // 2: press and release key 6
    apply_reset();
    base = ev_cnt;
    pressed = 16'h0040;
    frames(2);
    check("press6_early", keys_o, 16'h0);
    next_frame();
    check("press6_keys", keys_o, 16'h0040);
    check("press6_event", key_event_o, 1'b1);
    check("press6_code", key_code_o, 4'd6);
    pressed = 16'h0;
    @(negedge clk);
    check("press6_pulse_end", key_event_o, 1'b0);
    frames(2);
    check("release6_early", keys_o, 16'h0040);
    next_frame();
    check("release6_keys", keys_o, 16'h0);
    check("release6_code_hold", key_code_o, 4'd6);
    check("release6_events", ev_cnt - base, 1);

    // 3: bouncing key 6
    apply_reset();
    base = ev_cnt;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? 16'h0040 : 16'h0;
      next_frame();
      check("bounce_hold", keys_o, 16'h0);
    end
    pressed = 16'h0040;
    next_frame();
    check("bounce_settle1", keys_o, 16'h0);
    next_frame();
    check("bounce_settle2", keys_o, 16'h0040);
    check("bounce_events", ev_cnt - base, 1);

    // 4: add key 9 to key 5, then swap 5 for 0
    apply_reset();
    pressed = 16'h0020;
    frames(3);
    check("k5_keys", keys_o, 16'h0020);
    check("k5_code", key_code_o, 4'd5);
    base = ev_cnt;
    pressed = 16'h0220;
    frames(2);
    check("k9_early", keys_o, 16'h0020);
    next_frame();
    check("k9_keys", keys_o, 16'h0220);
    check("k9_event", key_event_o, 1'b1);
    check("k9_code", key_code_o, 4'd9);
    check("k9_events", ev_cnt - base, 1);
    pressed = 16'h0201;
    frames(3);
    check("swap_keys", keys_o, 16'h0201);
    check("swap_event", key_event_o, 1'b1);
    check("swap_code", key_code_o, 4'd0);
    check("swap_events", ev_cnt - base, 2);

    // 5: keys 0,1,4 with ghost 5
    apply_reset();
    base = ev_cnt;
    pressed = 16'h0033;
    frames(3);
`ifdef KEYPAD_GHOST_REJECT_EN
    check("ghost_keys", keys_o, 16'h0);
    check("ghost_events", ev_cnt - base, 0);
`else
    check("ghost_keys", keys_o, 16'h0033);
    check("ghost_code", key_code_o, 4'd0);
    check("ghost_events", ev_cnt - base, 1);
`endif

    // 6: reset in the middle of row 2
    apply_reset();
    pressed = 16'h0040;
    frames(3);
    check("mid_pre_keys", keys_o, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (row_o == 4'b1011) found = 1'b1;
    end
    check("row2_bound", {31'd0, found}, 32'd1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_row", row_o, 4'hF);
    check("mid_rst_keys", keys_o, 16'h0);
    check("mid_rst_state", state_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    base = ev_cnt;
    frames(2);
    check("mid_rel_early", keys_o, 16'h0);
    next_frame();
    check("mid_rel_keys", keys_o, 16'h0040);
    check("mid_rel_event", key_event_o, 1'b1);
    check("mid_rel_code", key_code_o, 4'd6);
    check("mid_rel_events", ev_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
